// File: rtl/orv64_div_iter.sv
// orv64_div_iter: iterative restoring divider for the M extension.
// Signed, unsigned and 32-bit word ops; optional leading-zero skip.
package orv64_div_pkg;
  typedef enum logic [2:0] {
    DIV_Q   = 3'd0,
    DIV_QU  = 3'd1,
    DIV_R   = 3'd2,
    DIV_RU  = 3'd3,
    DIV_QW  = 3'd4,
    DIV_QUW = 3'd5,
    DIV_RW  = 3'd6,
    DIV_RUW = 3'd7
  } orv64_div_type_t;
endpackage

module orv64_div_iter
  import orv64_div_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int BITS_PER_CYC = 1,
  parameter int EARLY_TERM   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  orv64_div_type_t req_type,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_SPECIAL,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic            live;
  orv64_div_type_t typ;
  logic [XLEN-1:0] opa, opb, quo, dvs, res;
  logic [XLEN:0]   rem;
  logic [CW-1:0]   cnt;
  logic            qneg, rneg;

  logic            t_w, t_rem, t_sgn;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [XLEN-1:0] a_min, a_sh;
  logic            a_neg, b_neg, dz, ovf;
  logic [CW-1:0]   lz, sh, n_cyc;
  logic [XLEN:0]   r_n;
  logic [XLEN-1:0] q_n;
  logic [XLEN-1:0] q_fix, r_fix, sel, res_n;
  logic            accept;

  function automatic logic [XLEN-1:0] ext32(
    input logic [XLEN-1:0] v,
    input logic            s
  );
    logic [XLEN-1:0] o;
    o = v;
    for (int i = 32; i < XLEN; i++) o[i] = s & v[31];
    return o;
  endfunction

  assign t_w    = typ[2] & (XLEN == 64);
  assign t_rem  = typ[1];
  assign t_sgn  = ~typ[0];
  assign accept = req_valid & req_ready;

  assign req_ready  = (state == S_IDLE) & live & ~kill;
  assign resp_valid = (state == S_DONE);
  assign resp_data  = res;

  // operand formation, special-case detection and skip amount
  always_comb begin
    a_ext = t_w ? ext32(opa, t_sgn) : opa;
    b_ext = t_w ? ext32(opb, t_sgn) : opb;
    a_neg = t_sgn & (t_w ? opa[31] : opa[XLEN-1]);
    b_neg = t_sgn & (t_w ? opb[31] : opb[XLEN-1]);
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    a_min = t_w ? ({XLEN{1'b1}} << 31)
                : ({XLEN{1'b1}} << (XLEN - 1));
    dz    = (b_ext == '0);
    ovf   = t_sgn & (a_ext == a_min) & (b_ext == '1);
    lz    = CW'(XLEN);
    for (int i = 0; i < XLEN; i++)
      if (a_mag[i]) lz = CW'(XLEN - 1 - i);
    if (EARLY_TERM != 0)
      sh = CW'((int'(lz) / BITS_PER_CYC) * BITS_PER_CYC);
    else
      sh = t_w ? CW'(XLEN - 32) : '0;
    a_sh  = a_mag << sh;
    n_cyc = CW'((XLEN - int'(sh)) / BITS_PER_CYC);
    if (n_cyc == '0) n_cyc = CW'(1);
  end

  // restoring steps retired in one CALC cycle
  always_comb begin
    r_n = rem;
    q_n = quo;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      r_n = {r_n[XLEN-1:0], q_n[XLEN-1]};
      q_n = {q_n[XLEN-2:0], 1'b0};
      if (r_n >= {1'b0, dvs}) begin
        r_n    = r_n - {1'b0, dvs};
        q_n[0] = 1'b1;
      end
    end
  end

  // sign correction and result selection
  always_comb begin
    q_fix = qneg ? -quo : quo;
    r_fix = rneg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    sel   = t_rem ? r_fix : q_fix;
    res_n = t_w ? ext32(sel, 1'b1) : sel;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state logic; kill overrides everything
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (accept) state_n = S_PREP;
      S_PREP:    state_n = (dz | ovf) ? S_SPECIAL : S_CALC;
      S_CALC:    if (cnt == CW'(1)) state_n = S_FIXUP;
      S_SPECIAL: state_n = S_DONE;
      S_FIXUP:   state_n = S_DONE;
      S_DONE:    if (resp_ready) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  // holds req_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      typ  <= DIV_Q;
      opa  <= '0;
      opb  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      res  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            opa <= req_rs1;
            opb <= req_rs2;
            typ <= req_type;
          end
        end
        S_PREP: begin
          dvs <= b_mag;
          cnt <= n_cyc;
          if (dz | ovf) begin
            quo  <= dz ? '1 : a_ext;
            rem  <= dz ? {1'b0, a_ext} : '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
          end else begin
            quo  <= a_sh;
            rem  <= '0;
            qneg <= a_neg ^ b_neg;
            rneg <= a_neg;
          end
        end
        S_CALC: begin
          rem <= r_n;
          quo <= q_n;
          cnt <= cnt - CW'(1);
        end
        S_SPECIAL, S_FIXUP: res <= res_n;
        default: ;
      endcase
    end
  end

endmodule
